// File: rtl/ula_operand_stage.sv
// Operand-issue stage ahead of the ULA.
// Two-entry operand queue with illegal-opcode rejection and optional forwarding.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   in_opcode, in_rs_idx, in_rt_idx, in_rd_idx, in_rs_data, in_rt_data
//                       decoded instruction and register-file read data
//   fwd_valid, fwd_idx, fwd_data
//                       writeback result; used only with ULA_OPSTAGE_FWD_EN
//   out_valid/out_ready ULA-side handshake for the head entry
//   A, B, opcode, out_rd_idx
//                       head entry fields, driven from registered storage
//   err_illegal         sticky illegal-opcode flag
//   illegal_cnt         saturating count of rejected instructions
//
// Build option: define ULA_OPSTAGE_FWD_EN to enable writeback forwarding.
module ula_operand_stage #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 5,
  parameter int IDX_W  = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [IDX_W-1:0]  in_rs_idx,
  input  logic [IDX_W-1:0]  in_rt_idx,
  input  logic [IDX_W-1:0]  in_rd_idx,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic              fwd_valid,
  input  logic [IDX_W-1:0]  fwd_idx,
  input  logic [DATA_W-1:0] fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OPC_W-1:0]  opcode,
  output logic [IDX_W-1:0]  out_rd_idx,
  output logic              err_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [IDX_W-1:0]  rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
`ifdef ULA_OPSTAGE_FWD_EN
    logic [IDX_W-1:0]  rs;
    logic [IDX_W-1:0]  rt;
`endif
  } ent_t;

  ent_t       mem [2];
  logic       rptr;
  logic       wptr;
  logic [1:0] count;
  logic [1:0] count_next;

  logic acc;
  logic legal;
  logic push;
  logic pop;
  logic bad;
  ent_t new_ent;

  // Opcodes with the top bit set are illegal.
  assign legal = ~in_opcode[OPC_W-1];
  assign acc   = in_valid & in_ready;
  assign push  = acc & legal;
  assign bad   = acc & ~legal;
  assign pop   = out_valid & out_ready;

  assign count_next = count
                    + {1'b0, push}
                    - {1'b0, pop};

`ifdef ULA_OPSTAGE_FWD_EN
  logic fwd_hit;
  logic live [2];

  assign fwd_hit = fwd_valid &&
                   (fwd_idx != '0);

  // An entry is live when it holds data
  // and is not leaving this cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      live[i] = (count == 2'd2) ||
                (count == 2'd1 &&
                 rptr == 1'(i));
      if (pop && rptr == 1'(i))
        live[i] = 1'b0;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid,
                        fwd_idx,
                        fwd_data};
`endif

  always_comb begin
    new_ent     = '0;
    new_ent.opc = in_opcode;
    new_ent.rd  = in_rd_idx;
    new_ent.a   = in_rs_data;
    new_ent.b   = in_rt_data;
`ifdef ULA_OPSTAGE_FWD_EN
    new_ent.rs  = in_rs_idx;
    new_ent.rt  = in_rt_idx;
    if (fwd_hit && fwd_idx == in_rs_idx)
      new_ent.a = fwd_data;
    if (fwd_hit && fwd_idx == in_rt_idx)
      new_ent.b = fwd_data;
`endif
    // Register 0 always reads as zero.
    if (in_rs_idx == '0)
      new_ent.a = '0;
    if (in_rt_idx == '0)
      new_ent.b = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0]      <= '0;
      mem[1]      <= '0;
      rptr        <= 1'b0;
      wptr        <= 1'b0;
      count       <= 2'd0;
      in_ready    <= 1'b1;
      err_illegal <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push && wptr == 1'(i)) begin
          mem[i] <= new_ent;
        end
`ifdef ULA_OPSTAGE_FWD_EN
        else if (fwd_hit && live[i]) begin
          if (mem[i].rs == fwd_idx)
            mem[i].a <= fwd_data;
          if (mem[i].rt == fwd_idx)
            mem[i].b <= fwd_data;
        end
`endif
      end
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      count    <= count_next;
      in_ready <= (count_next < 2'd2);
      if (bad) begin
        err_illegal <= 1'b1;
        if (illegal_cnt != '1)
          illegal_cnt <= illegal_cnt + 1'b1;
      end
    end
  end

  assign out_valid  = (count != 2'd0);
  assign A          = mem[rptr].a;
  assign B          = mem[rptr].b;
  assign opcode     = mem[rptr].opc;
  assign out_rd_idx = mem[rptr].rd;

endmodule

// File: tb/tb_ula_operand_stage.sv
// Directed bench for ula_operand_stage.
// Immediate assertions against hand-computed values.
module tb_ula_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [4:0]  in_rs_idx;
  logic [4:0]  in_rt_idx;
  logic [4:0]  in_rd_idx;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic        fwd_valid;
  logic [4:0]  fwd_idx;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  opcode;
  logic [4:0]  out_rd_idx;
  logic        err_illegal;
  logic [7:0]  illegal_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_b;

  always #5 clk = ~clk;

  ula_operand_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rs_idx  (in_rs_idx),
    .in_rt_idx  (in_rt_idx),
    .in_rd_idx  (in_rd_idx),
    .in_rs_data (in_rs_data),
    .in_rt_data (in_rt_data),
    .fwd_valid  (fwd_valid),
    .fwd_idx    (fwd_idx),
    .fwd_data   (fwd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .A          (A),
    .B          (B),
    .opcode     (opcode),
    .out_rd_idx (out_rd_idx),
    .err_illegal(err_illegal),
    .illegal_cnt(illegal_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op,
                       input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic [4:0] rd,
                       input logic [31:0] a,
                       input logic [31:0] b);
    in_valid   = 1'b1;
    in_opcode  = op;
    in_rs_idx  = rs;
    in_rt_idx  = rt;
    in_rd_idx  = rd;
    in_rs_data = a;
    in_rt_data = b;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_opcode = '0;
    in_rs_idx = '0;
    in_rt_idx = '0;
    in_rd_idx = '0;
    in_rs_data = '0;
    in_rt_data = '0;
    fwd_valid = 1'b0;
    fwd_idx = '0;
    fwd_data = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_rd", 32'(out_rd_idx), 0);
    chk("rst_err", 32'(err_illegal), 0);
    chk("rst_cnt", 32'(illegal_cnt), 0);

    // Single transfer, one-cycle latency.
    out_ready = 1'b1;
    drive(5'd1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    tick();
    in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_A", A, 5);
    chk("t1_B", B, 7);
    chk("t1_opc", 32'(opcode), 1);
    chk("t1_rd", 32'(out_rd_idx), 3);
    tick();
    chk("t1_drain", 32'(out_valid), 0);

    // Fill, backpressure, FIFO order.
    out_ready = 1'b0;
    drive(5'd2, 5'd1, 5'd2, 5'd4, 32'd10, 32'd11);
    tick();
    chk("f_ready1", 32'(in_ready), 1);
    drive(5'd3, 5'd1, 5'd2, 5'd5, 32'd20, 32'd21);
    tick();
    chk("f_ready2", 32'(in_ready), 0);
    drive(5'd4, 5'd1, 5'd2, 5'd6, 32'd30, 32'd31);
    tick();
    chk("f_held_ready", 32'(in_ready), 0);
    chk("f_held_A", A, 10);
    tick();
    chk("f_stable_A", A, 10);
    chk("f_stable_opc", 32'(opcode), 2);
    out_ready = 1'b1;
    tick();
    chk("f_pop1_ready", 32'(in_ready), 1);
    chk("f_pop1_A", A, 20);
    chk("f_pop1_rd", 32'(out_rd_idx), 5);
    tick();
    in_valid = 1'b0;
    chk("f_pushpop_valid", 32'(out_valid), 1);
    chk("f_pushpop_A", A, 30);
    chk("f_pushpop_B", B, 31);
    chk("f_pushpop_opc", 32'(opcode), 4);
    tick();
    chk("f_empty", 32'(out_valid), 0);

    // Illegal opcodes.
    drive(5'b10011, 5'd1, 5'd2, 5'd7, 32'd1, 32'd2);
    tick();
    in_valid = 1'b0;
    chk("il_valid", 32'(out_valid), 0);
    chk("il_err", 32'(err_illegal), 1);
    chk("il_cnt", 32'(illegal_cnt), 1);
    drive(5'b11111, 5'd1, 5'd2, 5'd7, 32'd1, 32'd2);
    for (int i = 0; i < 253; i++)
      tick();
    chk("il_cnt254", 32'(illegal_cnt), 254);
    for (int i = 0; i < 47; i++)
      tick();
    in_valid = 1'b0;
    chk("il_cnt_sat", 32'(illegal_cnt), 255);
    chk("il_err_sticky", 32'(err_illegal), 1);
    chk("il_no_valid", 32'(out_valid), 0);

    // Register 0 reads as zero.
    out_ready = 1'b0;
    drive(5'd5, 5'd0, 5'd0, 5'd8,
          32'hDEADBEEF, 32'hCAFEF00D);
    tick();
    in_valid = 1'b0;
    chk("r0_valid", 32'(out_valid), 1);
    chk("r0_A", A, 0);
    chk("r0_B", B, 0);
    out_ready = 1'b1;
    tick();
    chk("r0_drain", 32'(out_valid), 0);

    // Forwarding onto a held entry.
    out_ready = 1'b0;
    drive(5'd6, 5'd3, 5'd4, 5'd9,
          32'h111, 32'h222);
    tick();
    in_valid = 1'b0;
    chk("fw_B0", B, 32'h222);
    fwd_valid = 1'b1;
    fwd_idx = 5'd4;
    fwd_data = 32'h1234;
    tick();
`ifdef ULA_OPSTAGE_FWD_EN
    exp_b = 32'h1234;
`else
    exp_b = 32'h222;
`endif
    chk("fw_B1", B, exp_b);
    chk("fw_A1", A, 32'h111);
    fwd_idx = 5'd0;
    fwd_data = 32'h9999;
    tick();
    fwd_valid = 1'b0;
    chk("fw_idx0_B", B, exp_b);
    chk("fw_idx0_A", A, 32'h111);

    // Reset with a full queue and a pop pending.
    drive(5'd7, 5'd5, 5'd6, 5'd10,
          32'h333, 32'h444);
    tick();
    in_valid = 1'b0;
    chk("full_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_valid", 32'(out_valid), 0);
    chk("rr_ready", 32'(in_ready), 1);
    chk("rr_cnt", 32'(illegal_cnt), 0);
    chk("rr_err", 32'(err_illegal), 0);
    chk("rr_A", A, 0);
    tick();
    chk("rr_stay_empty", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
